button_event_arbiter: RTL and testbench
=======================================

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter N_BUTTONS, default 4: number of debounced button channels.
REQ-002 SHALL have parameter LONG_TICKS, default 1000: clk cycles of continuous high level that make a long press.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port levels  input  N_BUTTONS  debounced button levels, 1 = pressed.
REQ-006 SHALL have port event_valid  output  1  an event is offered.
REQ-007 SHALL have port event_ready  input  1  consumer accepts the offered event.
REQ-008 SHALL have port event_channel  output  $clog2(N_BUTTONS) (min 1)  channel index of the offered event.
REQ-009 SHALL have port event_kind  output  2  EV_PRESS=0, EV_RELEASE=1, EV_LONG=2.
REQ-010 SHALL have port overrun  output  N_BUTTONS  sticky per-channel flag: an event was dropped.
REQ-011 SHALL have port overrun_clear  input  1  single-cycle pulse that clears all overrun bits.

Function
REQ-012 SHALL register levels into prev each cycle; press = levels & ~prev, release = ~levels & prev.
REQ-013 SHALL hold three pending bits per channel (press, release, long), set on the matching detection.
REQ-014 SHALL run a per-channel hold counter: clear while level low, increment while high, saturate at LONG_TICKS-1.
REQ-015 SHALL set the long pending bit exactly once per press, in the cycle the counter reaches LONG_TICKS-1; no further long event until a release occurs.
REQ-016 SHALL, on detection of a kind whose pending bit is already set and not being cleared that cycle, drop the event and set overrun[ch].
REQ-017 SHALL keep a pending bit set if a new detection coincides with its acceptance cleanup; no overrun in that case.
REQ-018 SHALL implement FSM S_IDLE -> S_OFFER when any pending bit is set; S_OFFER -> S_IDLE when event_valid & event_ready.
REQ-019 SHALL, on S_IDLE exit, pick the channel round-robin, starting at last_grant+1 modulo N_BUTTONS; within that channel, priority press > long > release.
REQ-020 SHALL latch event_channel/event_kind on entry to S_OFFER and hold them, with event_valid=1, stable until accepted.
REQ-021 SHALL, on acceptance, clear the offered pending bit and set last_grant to event_channel.
REQ-022 SHALL drive event_valid=1 only in S_OFFER; event_ready is ignored in S_IDLE.
REQ-023 SHALL offer an event two cycles after the edge that samples the level change (pending set at +1, valid at +2) when idle; peak throughput is one event per two cycles.
REQ-024 SHALL give overrun_clear priority below a simultaneous new overrun: the bit set that cycle stays set.

Reset
REQ-025 SHALL, while rst_n=0, force: state=S_IDLE, prev=0, all pending bits=0, counters=0, last_grant=N_BUTTONS-1, event_valid=0, event_channel=0, event_kind=EV_PRESS, overrun=0.
REQ-026 SHALL treat any channel high at reset release as a fresh press, detected on the first clock edge.
REQ-027 SHALL drop an offered but unaccepted event on reset assertion mid-handshake.

Structure
REQ-028 SHALL place the event_kind enum (EV_PRESS, EV_RELEASE, EV_LONG) and the FSM state enum in shared package button_pkg.
REQ-029 SHALL contain one sub-module, button_channel_tracker, instantiated per channel: prev register, hold counter, three pending bits, overrun bit. Arbitration and the FSM stay in the top module.

Verification
REQ-030 SHALL cover: levels[2] 0->1, event_ready=1 -> event_valid at +2 cycles, channel=2, kind=EV_PRESS, then idle.
REQ-031 SHALL cover: LONG_TICKS=8, channel 0 held high 20 cycles, then low, ready=1 -> exactly PRESS, LONG, RELEASE on channel 0, in that order.
REQ-032 SHALL cover: press on channels 0,1,3 in the same cycle, ready=1, last_grant=3 -> grants in order 0, 1, 3.
REQ-033 SHALL cover: ready=0, channel 1 pressed, released, pressed again -> one PRESS and one RELEASE pending, overrun[1]=1; offered outputs stay stable while held.
REQ-034 SHALL cover: rst_n pulsed low while event_valid=1 -> all outputs at REQ-025 values immediately, without a clock edge.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types for the button event arbiter.
// Event kinds, arbiter states and per-channel pending bundle.
package button_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2
  } ev_kind_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic press;
    logic rel;
    logic lng;
  } pend_t;

  function automatic int unsigned clog2_min1(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_channel_tracker.sv
// One button channel: edge detect, hold counter,
// pending press/release/long bits and sticky overrun.
module button_channel_tracker
  import button_pkg::*;
#(
  parameter int unsigned LONG_TICKS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  input  logic clr_press,
  input  logic clr_rel,
  input  logic clr_lng,
  input  logic overrun_clear,
  output logic pend_press,
  output logic pend_rel,
  output logic pend_lng,
  output logic overrun
);

  localparam int unsigned CW = clog2_min1(LONG_TICKS);
  localparam logic [CW-1:0] SAT = CW'(LONG_TICKS - 1);

  logic          prev;
  logic [CW-1:0] cnt;
  pend_t         pend;
  pend_t         pend_n;
  pend_t         det;
  pend_t         clr;
  logic          drop;

  assign clr = '{press: clr_press, rel: clr_rel, lng: clr_lng};

  // Long fires on the edge the counter lands on SAT, never again
  // until a low level clears the counter.
  always_comb begin
    det.press = level & ~prev;
    det.rel   = ~level & prev;
    det.lng   = level & (cnt != SAT)
              & ((cnt + 1'b1) == SAT);
    drop      = |(det & pend & ~clr);
    pend_n    = pend_t'((pend & ~clr) | det);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= 1'b0;
      cnt     <= '0;
      pend    <= '0;
      overrun <= 1'b0;
    end else begin
      prev <= level;
      if (!level)
        cnt <= '0;
      else if (cnt != SAT)
        cnt <= cnt + 1'b1;
      pend <= pend_n;
      if (drop)
        overrun <= 1'b1;
      else if (overrun_clear)
        overrun <= 1'b0;
    end
  end

  assign pend_press = pend.press;
  assign pend_rel   = pend.rel;
  assign pend_lng   = pend.lng;

endmodule

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter turning per-channel button events
// into a single valid/ready event stream.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter  int unsigned N_BUTTONS  = 4,
  parameter  int unsigned LONG_TICKS = 1000,
  localparam int unsigned CHW = clog2_min1(N_BUTTONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] levels,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [CHW-1:0]       event_channel,
  output logic [1:0]           event_kind,
  output logic [N_BUTTONS-1:0] overrun,
  input  logic                 overrun_clear
);

  localparam logic [CHW-1:0] LAST_CH = CHW'(N_BUTTONS - 1);
  localparam logic [N_BUTTONS-1:0] ONE = N_BUTTONS'(1);

  arb_state_t state, state_n;
  ev_kind_t   kind_q, kind_n, pick_kind;

  logic [CHW-1:0] ch_q, ch_n;
  logic [CHW-1:0] last_grant, grant_n;
  logic [CHW-1:0] cand, pick_ch;
  logic           pick_found;
  logic           accept;

  logic [N_BUTTONS-1:0] pend_press, pend_rel, pend_lng;
  logic [N_BUTTONS-1:0] clr_press, clr_rel, clr_lng;
  logic [N_BUTTONS-1:0] chan_any, sel;

  assign event_valid   = (state == S_OFFER);
  assign event_channel = ch_q;
  assign event_kind    = kind_q;
  assign accept        = event_valid & event_ready;

  assign sel       = accept ? (ONE << ch_q) : '0;
  assign clr_press = (kind_q == EV_PRESS)   ? sel : '0;
  assign clr_rel   = (kind_q == EV_RELEASE) ? sel : '0;
  assign clr_lng   = (kind_q == EV_LONG)    ? sel : '0;
  assign chan_any  = pend_press | pend_rel | pend_lng;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    button_channel_tracker #(
      .LONG_TICKS(LONG_TICKS)
    ) u_trk (
      .clk          (clk),
      .rst_n        (rst_n),
      .level        (levels[g]),
      .clr_press    (clr_press[g]),
      .clr_rel      (clr_rel[g]),
      .clr_lng      (clr_lng[g]),
      .overrun_clear(overrun_clear),
      .pend_press   (pend_press[g]),
      .pend_rel     (pend_rel[g]),
      .pend_lng     (pend_lng[g]),
      .overrun      (overrun[g])
    );
  end

  // Scan starts one past the last grant and wraps.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    cand       = last_grant;
    for (int i = 0; i < N_BUTTONS; i++) begin
      cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
      if (!pick_found && chan_any[cand]) begin
        pick_found = 1'b1;
        pick_ch    = cand;
      end
    end
  end

  always_comb begin
    if (pend_press[pick_ch])
      pick_kind = EV_PRESS;
    else if (pend_lng[pick_ch])
      pick_kind = EV_LONG;
    else
      pick_kind = EV_RELEASE;
  end

  always_comb begin
    state_n = state;
    ch_n    = ch_q;
    kind_n  = kind_q;
    grant_n = last_grant;
    unique case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_n = S_OFFER;
          ch_n    = pick_ch;
          kind_n  = pick_kind;
        end
      end
      S_OFFER: begin
        if (event_ready) begin
          state_n = S_IDLE;
          grant_n = ch_q;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ch_q       <= '0;
      kind_q     <= EV_PRESS;
      last_grant <= LAST_CH;
    end else begin
      state      <= state_n;
      ch_q       <= ch_n;
      kind_q     <= kind_n;
      last_grant <= grant_n;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed + random bench for button_event_arbiter against
// an event-level reference model.
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int LT = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] levels = '0;
  logic         event_valid;
  logic         event_ready = 1'b0;
  logic [1:0]   event_channel;
  logic [1:0]   event_kind;
  logic [N-1:0] overrun;
  logic         overrun_clear = 1'b0;

  button_event_arbiter #(
    .N_BUTTONS (N),
    .LONG_TICKS(LT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .levels       (levels),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_channel(event_channel),
    .event_kind   (event_kind),
    .overrun      (overrun),
    .overrun_clear(overrun_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int kind;
  } ev_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: run lengths, pending event sets, offered event.
  int     m_run [N];
  bit     m_prev[N];
  bit     m_pend[N][3];
  bit     m_ovr [N];
  bit     m_valid;
  int     m_ch, m_kind, m_last;
  ev_t    obs[$];

  task automatic check(input string tag, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0;
      m_prev[c] = 0;
      m_ovr[c] = 0;
      for (int k = 0; k < 3; k++) m_pend[c][k] = 0;
    end
    m_valid = 0;
    m_ch = 0;
    m_kind = 0;
    m_last = N - 1;
  endtask

  task automatic model_step();
    bit acc;
    bit lv, clr, hit;
    bit det[3];
    int pick, pkind;
    acc = m_valid && event_ready;
    pick = -1;
    pkind = 0;
    if (acc)
      obs.push_back('{ch: int'(event_channel), kind: int'(event_kind)});
    if (!m_valid)
      for (int i = 1; i <= N; i++) begin
        int c = (m_last + i) % N;
        if (pick < 0 && (m_pend[c][0] || m_pend[c][1] || m_pend[c][2])) begin
          pick = c;
          pkind = m_pend[c][0] ? 0 : (m_pend[c][2] ? 2 : 1);
        end
      end
    for (int c = 0; c < N; c++) begin
      lv = levels[c];
      m_run[c] = lv ? m_run[c] + 1 : 0;
      det[0] = lv && !m_prev[c];
      det[1] = !lv && m_prev[c];
      det[2] = lv && (m_run[c] == LT - 1);
      hit = 0;
      for (int k = 0; k < 3; k++) begin
        clr = acc && (m_ch == c) && (m_kind == k);
        if (det[k]) begin
          if (m_pend[c][k] && !clr) hit = 1;
          m_pend[c][k] = 1;
        end else if (clr) begin
          m_pend[c][k] = 0;
        end
      end
      if (hit) m_ovr[c] = 1;
      else if (overrun_clear) m_ovr[c] = 0;
      m_prev[c] = lv;
    end
    if (acc) begin
      m_valid = 0;
      m_last = m_ch;
    end else if (pick >= 0) begin
      m_valid = 1;
      m_ch = pick;
      m_kind = pkind;
    end
  endtask

  task automatic compare_all();
    int ov;
    ov = 0;
    for (int c = 0; c < N; c++) ov |= int'(m_ovr[c]) << c;
    check("valid", int'(event_valid), int'(m_valid));
    check("channel", int'(event_channel), m_ch);
    check("kind", int'(event_kind), m_kind);
    check("overrun", int'(overrun), ov);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", int'(event_valid), 0);
    check("rst_channel", int'(event_channel), 0);
    check("rst_kind", int'(event_kind), 0);
    check("rst_overrun", int'(overrun), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_ev(input string tag, input int idx,
                          input int ch, input int kind);
    if (idx < obs.size()) begin
      check({tag, "_ch"}, obs[idx].ch, ch);
      check({tag, "_kind"}, obs[idx].kind, kind);
    end else begin
      check({tag, "_missing"}, obs.size(), idx + 1);
    end
  endtask

  initial begin
    do_reset();

    // Single press on channel 2: valid two edges later.
    event_ready = 1'b1;
    levels = 4'b0100;
    tick();
    check("p2_plus1_valid", int'(event_valid), 0);
    tick();
    check("p2_plus2_valid", int'(event_valid), 1);
    check("p2_plus2_ch", int'(event_channel), 2);
    check("p2_plus2_kind", int'(event_kind), 0);
    tick();
    check("p2_idle", int'(event_valid), 0);
    levels = 4'b0000;
    repeat (6) tick();

    // Long press on channel 0.
    obs.delete();
    levels = 4'b0001;
    repeat (20) tick();
    levels = 4'b0000;
    repeat (10) tick();
    check("long_count", obs.size(), 3);
    check_ev("long_e0", 0, 0, 0);
    check_ev("long_e1", 1, 0, 2);
    check_ev("long_e2", 2, 0, 1);

    // Simultaneous presses after reset, round-robin from channel 0.
    levels = 4'b0000;
    do_reset();
    obs.delete();
    levels = 4'b1011;
    repeat (7) tick();
    check("rr_count", obs.size(), 3);
    check_ev("rr_e0", 0, 0, 0);
    check_ev("rr_e1", 1, 1, 0);
    check_ev("rr_e2", 2, 3, 0);
    levels = 4'b0000;
    repeat (14) tick();

    // Back-pressure on channel 1: press, release, press again.
    event_ready = 1'b0;
    do_reset();
    levels = 4'b0010;
    tick();
    levels = 4'b0000;
    tick();
    levels = 4'b0010;
    tick();
    check("bp_overrun", int'(overrun), 2);
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_valid", int'(event_valid), 1);
      check("bp_hold_ch", int'(event_channel), 1);
      check("bp_hold_kind", int'(event_kind), 0);
      if (i < 3) tick();
    end
    obs.delete();
    event_ready = 1'b1;
    repeat (4) tick();
    check("bp_count", obs.size(), 2);
    check_ev("bp_e0", 0, 1, 0);
    check_ev("bp_e1", 1, 1, 1);
    levels = 4'b0000;
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    check("bp_ovr_clr", int'(overrun), 0);
    repeat (8) tick();

    // Reset asserted mid-handshake; level still high afterwards.
    event_ready = 1'b0;
    levels = 4'b0100;
    tick();
    tick();
    check("mid_valid", int'(event_valid), 1);
    do_reset();
    tick();
    tick();
    check("post_rst_valid", int'(event_valid), 1);
    check("post_rst_ch", int'(event_channel), 2);
    check("post_rst_kind", int'(event_kind), 0);
    event_ready = 1'b1;
    levels = 4'b0000;
    repeat (8) tick();

    // Random levels, back-pressure and overrun clears.
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 11) == 0) levels[c] = ~levels[c];
      event_ready = ($urandom_range(0, 3) != 0);
      overrun_clear = ($urandom_range(0, 23) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
